// File: rtl/mips_pkg.sv
// mips_pkg: shared ALU op codes, datapath width defaults and forward-select encoding
package mips_pkg;
    localparam int DEF_DATA_W  = 32;
    localparam int DEF_RADDR_W = 5;
    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [1:0] FWD_REG   = 2'b00;
    localparam logic [1:0] FWD_MEMWB = 2'b01;
    localparam logic [1:0] FWD_EXMEM = 2'b10;
endpackage

// File: rtl/forward_unit.sv
// forward_unit: picks EX/MEM, MEM/WB or register-file data for rs and rt; r0 is never forwarded
module forward_unit
    import mips_pkg::*;
#(
    parameter int RADDR_W = DEF_RADDR_W
) (
    input  logic [RADDR_W-1:0] rs,
    input  logic [RADDR_W-1:0] rt,
    input  logic               exmem_reg_write,
    input  logic [RADDR_W-1:0] exmem_rd,
    input  logic               memwb_reg_write,
    input  logic [RADDR_W-1:0] memwb_rd,
    output logic [1:0]         fwd_a,
    output logic [1:0]         fwd_b
);
    function automatic logic [1:0] sel(input logic [RADDR_W-1:0] r);
        return (exmem_reg_write && exmem_rd != '0 && exmem_rd == r) ? FWD_EXMEM :
               (memwb_reg_write && memwb_rd != '0 && memwb_rd == r) ? FWD_MEMWB : FWD_REG;
    endfunction
    assign fwd_a = sel(rs);
    assign fwd_b = sel(rt);
endmodule

// File: rtl/id_ex_operand_stage.sv
// id_ex_operand_stage: ID/EX register with bubbles, forwarding and ALU operand prep (IDEX_ZEXT_LOGIC_EN zero-extends andi/ori immediates)
module id_ex_operand_stage
    import mips_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int RADDR_W = DEF_RADDR_W,
    parameter int IMM_W   = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               stall,
    input  logic               flush,
    input  logic               id_valid,
    input  logic [DATA_W-1:0]  id_rs_data,
    input  logic [DATA_W-1:0]  id_rt_data,
    input  logic [IMM_W-1:0]   id_imm,
    input  logic [RADDR_W-1:0] id_rs_addr,
    input  logic [RADDR_W-1:0] id_rt_addr,
    input  logic [RADDR_W-1:0] id_rd_addr,
    input  logic [3:0]         id_alu_ctrl,
    input  logic               id_alu_src,
    input  logic               id_reg_dst,
    input  logic               id_reg_write,
    input  logic               id_mem_read,
    input  logic               id_mem_write,
    input  logic               id_mem_to_reg,
    input  logic               id_branch,
    input  logic               exmem_reg_write,
    input  logic [RADDR_W-1:0] exmem_rd,
    input  logic [DATA_W-1:0]  exmem_result,
    input  logic               memwb_reg_write,
    input  logic [RADDR_W-1:0] memwb_rd,
    input  logic [DATA_W-1:0]  memwb_result,
    output logic [DATA_W-1:0]  ex_a,
    output logic [DATA_W-1:0]  ex_b,
    output logic [3:0]         ex_alu_ctrl,
    output logic [DATA_W-1:0]  ex_store_data,
    output logic [RADDR_W-1:0] ex_write_reg,
    output logic               ex_valid,
    output logic               ex_reg_write,
    output logic               ex_mem_read,
    output logic               ex_mem_write,
    output logic               ex_mem_to_reg,
    output logic               ex_branch,
    output logic               load_use_stall
);
    logic               src_q;
    logic [3:0]         ctrl_q;
    logic [RADDR_W-1:0] rs_q, rt_q, wr_q;
    logic [DATA_W-1:0]  rsd_q, rtd_q, imm_q;
    logic [DATA_W-1:0]  ext_imm, fwd_rs, fwd_rt;
    logic [1:0]         fa, fb;
    logic               zext, clr;

`ifdef IDEX_ZEXT_LOGIC_EN
    assign zext = id_alu_src & (id_alu_ctrl == ALU_AND | id_alu_ctrl == ALU_OR);
`else
    assign zext = 1'b0;
`endif
    assign ext_imm = {{(DATA_W-IMM_W){id_imm[IMM_W-1] & ~zext}}, id_imm};

    assign load_use_stall = ex_valid & ex_mem_read & (rt_q != '0) & id_valid &
                            (rt_q == id_rs_addr | (rt_q == id_rt_addr & ~id_alu_src));

    // an invalid ID slot is captured as a bubble so stray control bits never reach EX
    assign clr = reset | flush | load_use_stall | (~stall & ~id_valid);

    // pipeline register: clear to a bubble, hold on stall, otherwise capture ID
    always_ff @(posedge clk) begin
        if (clr) begin
            {ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_branch, src_q} <= '0;
            ctrl_q <= ALU_AND;
            rs_q   <= '0;
            rt_q   <= '0;
            wr_q   <= '0;
            rsd_q  <= '0;
            rtd_q  <= '0;
            imm_q  <= '0;
        end else if (!stall) begin
            ex_valid      <= 1'b1;
            ex_reg_write  <= id_reg_write;
            ex_mem_read   <= id_mem_read;
            ex_mem_write  <= id_mem_write;
            ex_mem_to_reg <= id_mem_to_reg;
            ex_branch     <= id_branch;
            src_q         <= id_alu_src;
            ctrl_q        <= id_alu_ctrl;
            rs_q          <= id_rs_addr;
            rt_q          <= id_rt_addr;
            wr_q          <= id_reg_dst ? id_rd_addr : id_rt_addr;
            rsd_q         <= id_rs_data;
            rtd_q         <= id_rt_data;
            imm_q         <= ext_imm;
        end
    end

    forward_unit #(.RADDR_W(RADDR_W)) u_fwd (
        .rs              (rs_q),
        .rt              (rt_q),
        .exmem_reg_write (exmem_reg_write),
        .exmem_rd        (exmem_rd),
        .memwb_reg_write (memwb_reg_write),
        .memwb_rd        (memwb_rd),
        .fwd_a           (fa),
        .fwd_b           (fb)
    );

    // operand muxes driven straight into the ALU
    always_comb begin
        fwd_rs = fa == FWD_EXMEM ? exmem_result : fa == FWD_MEMWB ? memwb_result : rsd_q;
        fwd_rt = fb == FWD_EXMEM ? exmem_result : fb == FWD_MEMWB ? memwb_result : rtd_q;
    end

    assign ex_a          = fwd_rs;
    assign ex_b          = src_q ? imm_q : fwd_rt;
    assign ex_store_data = fwd_rt;
    assign ex_alu_ctrl   = ctrl_q;
    assign ex_write_reg  = wr_q;
endmodule

// File: tb/tb_id_ex_operand_stage.sv
// tb_id_ex_operand_stage: directed and random checks of the ID/EX operand stage against a transaction-level model
module tb_id_ex_operand_stage;
    import mips_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset, stall, flush, id_valid;
    logic [31:0] id_rs_data, id_rt_data, exmem_result, memwb_result;
    logic [15:0] id_imm;
    logic [4:0] id_rs_addr, id_rt_addr, id_rd_addr, exmem_rd, memwb_rd;
    logic [3:0] id_alu_ctrl;
    logic id_alu_src, id_reg_dst, id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg, id_branch;
    logic exmem_reg_write, memwb_reg_write;
    logic [31:0] ex_a, ex_b, ex_store_data;
    logic [3:0] ex_alu_ctrl;
    logic [4:0] ex_write_reg;
    logic ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_branch, load_use_stall;

    id_ex_operand_stage dut (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush), .id_valid(id_valid),
        .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
        .id_rs_addr(id_rs_addr), .id_rt_addr(id_rt_addr), .id_rd_addr(id_rd_addr),
        .id_alu_ctrl(id_alu_ctrl), .id_alu_src(id_alu_src), .id_reg_dst(id_reg_dst),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
        .id_mem_to_reg(id_mem_to_reg), .id_branch(id_branch),
        .exmem_reg_write(exmem_reg_write), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
        .memwb_reg_write(memwb_reg_write), .memwb_rd(memwb_rd), .memwb_result(memwb_result),
        .ex_a(ex_a), .ex_b(ex_b), .ex_alu_ctrl(ex_alu_ctrl), .ex_store_data(ex_store_data),
        .ex_write_reg(ex_write_reg), .ex_valid(ex_valid), .ex_reg_write(ex_reg_write),
        .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_mem_to_reg(ex_mem_to_reg),
        .ex_branch(ex_branch), .load_use_stall(load_use_stall)
    );

    typedef struct packed {
        logic v, rw, mr, mw, m2r, br, src;
        logic [3:0] op;
        logic [4:0] rs, rt, wr;
        logic [31:0] rsd, rtd, imm;
    } instr_t;

    instr_t m;
    int total = 0;
    int bad = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", n, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] fwd(input logic [4:0] r, input logic [31:0] d);
        if (r != 0 && exmem_reg_write && exmem_rd == r) return exmem_result;
        if (r != 0 && memwb_reg_write && memwb_rd == r) return memwb_result;
        return d;
    endfunction

    function automatic logic hazard();
        return m.v && m.mr && m.rt != 0 && id_valid &&
               (m.rt == id_rs_addr || (m.rt == id_rt_addr && !id_alu_src));
    endfunction

    function automatic logic [31:0] imm_ext();
        int s;
        s = $signed(id_imm);
`ifdef IDEX_ZEXT_LOGIC_EN
        if (id_alu_src && (id_alu_ctrl == ALU_AND || id_alu_ctrl == ALU_OR)) return {16'h0, id_imm};
`endif
        return s;
    endfunction

    always @(posedge clk) begin
        if (reset || flush || hazard() || (!stall && !id_valid)) m <= '0;
        else if (!stall)
            m <= '{v: 1'b1, rw: id_reg_write, mr: id_mem_read, mw: id_mem_write, m2r: id_mem_to_reg,
                   br: id_branch, src: id_alu_src, op: id_alu_ctrl, rs: id_rs_addr, rt: id_rt_addr,
                   wr: id_reg_dst ? id_rd_addr : id_rt_addr, rsd: id_rs_data, rtd: id_rt_data,
                   imm: imm_ext()};
    end

    always @(negedge clk) if (chk_en) begin
        chk("ex_a", ex_a, fwd(m.rs, m.rsd));
        chk("ex_b", ex_b, m.src ? m.imm : fwd(m.rt, m.rtd));
        chk("ex_store_data", ex_store_data, fwd(m.rt, m.rtd));
        chk("ex_alu_ctrl", 32'(ex_alu_ctrl), 32'(m.op));
        chk("ex_write_reg", 32'(ex_write_reg), 32'(m.wr));
        chk("ex_ctrl_bits", 32'({ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_branch}),
            32'({m.v, m.rw, m.mr, m.mw, m.m2r, m.br}));
        chk("load_use_stall", 32'(load_use_stall), 32'(hazard()));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        {stall, flush, id_valid, id_alu_src, id_reg_dst, id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg, id_branch} = '0;
        {id_rs_data, id_rt_data, id_imm, id_rs_addr, id_rt_addr, id_rd_addr, id_alu_ctrl} = '0;
        {exmem_reg_write, exmem_rd, exmem_result, memwb_reg_write, memwb_rd, memwb_result} = '0;
    endtask

    task automatic set_id(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                          input logic [31:0] rsd, input logic [31:0] rtd, input logic [15:0] imm,
                          input logic [3:0] op, input logic src, input logic dst, input logic mr);
        id_valid = 1'b1;
        id_rs_addr = rs; id_rt_addr = rt; id_rd_addr = rd;
        id_rs_data = rsd; id_rt_data = rtd; id_imm = imm;
        id_alu_ctrl = op; id_alu_src = src; id_reg_dst = dst;
        id_reg_write = 1'b1; id_mem_read = mr; id_mem_to_reg = mr;
        id_mem_write = 1'b0; id_branch = 1'b0;
    endtask

    logic [3:0] ops [5] = '{ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_SLT};

    initial begin
        idle();
        reset = 1'b1;
        tick();
        chk_en = 1'b1;
        reset = 1'b0;
        chk("rst_valid", 32'(ex_valid), 32'h0);
        chk("rst_a", ex_a, 32'h0);
        set_id(5'd4, 5'd6, 5'd8, 32'h1234, 32'h5678, 16'h0, ALU_SUB, 1'b0, 1'b1, 1'b0);
        tick();
        chk("mid_valid", 32'(ex_valid), 32'h1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("mid_rst_valid", 32'(ex_valid), 32'h0);
        chk("mid_rst_rw", 32'(ex_reg_write), 32'h0);
        chk("mid_rst_ctrl", 32'(ex_alu_ctrl), 32'h0);
        chk("mid_rst_wr", 32'(ex_write_reg), 32'h0);
        set_id(5'd3, 5'd9, 5'd7, 32'hAAAA, 32'hBBBB, 16'h0, ALU_ADD, 1'b0, 1'b1, 1'b0);
        tick();
        chk("wr_rd", 32'(ex_write_reg), 32'd7);
        chk("add_ctrl", 32'(ex_alu_ctrl), 32'h2);
        id_reg_dst = 1'b0;
        tick();
        chk("wr_rt", 32'(ex_write_reg), 32'd9);
        stall = 1'b1;
        exmem_reg_write = 1'b1; exmem_rd = 5'd3; exmem_result = 32'h11;
        memwb_reg_write = 1'b1; memwb_rd = 5'd3; memwb_result = 32'h22;
        #1 chk("fwd_exmem", ex_a, 32'h11);
        chk("fwd_sd_none", ex_store_data, 32'hBBBB);
        exmem_reg_write = 1'b0;
        #1 chk("fwd_memwb", ex_a, 32'h22);
        stall = 1'b0;
        exmem_reg_write = 1'b1; exmem_rd = 5'd0; memwb_rd = 5'd0;
        id_rs_addr = 5'd0; id_rs_data = 32'h55;
        tick();
        chk("fwd_r0", ex_a, 32'h55);
        stall = 1'b1;
        id_rs_data = 32'h99;
        repeat (3) begin
            tick();
            chk("stall_a", ex_a, 32'h55);
            chk("stall_valid", 32'(ex_valid), 32'h1);
        end
        flush = 1'b1;
        tick();
        flush = 1'b0;
        stall = 1'b0;
        chk("flush_over_stall", 32'(ex_valid), 32'h0);
        exmem_reg_write = 1'b0; memwb_reg_write = 1'b0;
        set_id(5'd1, 5'd2, 5'd0, 32'h0, 32'h0, 16'hFFFC, ALU_ADD, 1'b1, 1'b0, 1'b0);
        tick();
        chk("addi_imm", ex_b, 32'hFFFF_FFFC);
        id_imm = 16'h8000; id_alu_ctrl = ALU_OR;
        tick();
`ifdef IDEX_ZEXT_LOGIC_EN
        chk("ori_imm", ex_b, 32'h0000_8000);
`else
        chk("ori_imm", ex_b, 32'hFFFF_8000);
`endif
        set_id(5'd1, 5'd5, 5'd0, 32'h0, 32'h0, 16'h4, ALU_ADD, 1'b1, 1'b0, 1'b1);
        tick();
        set_id(5'd5, 5'd2, 5'd6, 32'h0, 32'h0, 16'h0, ALU_ADD, 1'b0, 1'b1, 1'b0);
        #1 chk("lu_rs", 32'(load_use_stall), 32'h1);
        tick();
        chk("lu_bubble", 32'(ex_valid), 32'h0);
        chk("lu_once", 32'(load_use_stall), 32'h0);
        tick();
        chk("lu_resume", 32'(ex_valid), 32'h1);
        set_id(5'd1, 5'd5, 5'd0, 32'h0, 32'h0, 16'h4, ALU_ADD, 1'b1, 1'b0, 1'b1);
        tick();
        set_id(5'd6, 5'd5, 5'd0, 32'h0, 32'h0, 16'h8, ALU_ADD, 1'b1, 1'b0, 1'b0);
        #1 chk("lu_imm_none", 32'(load_use_stall), 32'h0);
        id_alu_src = 1'b0;
        #1 chk("lu_rt", 32'(load_use_stall), 32'h1);
        tick();
        repeat (3000) begin
            reset = ($urandom_range(49) == 0);
            stall = ($urandom_range(4) == 0);
            flush = ($urandom_range(9) == 0);
            id_valid = ($urandom_range(7) != 0);
            id_rs_addr = 5'($urandom_range(7)); id_rt_addr = 5'($urandom_range(7)); id_rd_addr = 5'($urandom_range(7));
            id_rs_data = $urandom; id_rt_data = $urandom; id_imm = 16'($urandom);
            id_alu_ctrl = ops[$urandom_range(4)];
            {id_alu_src, id_reg_dst, id_reg_write, id_mem_write, id_mem_to_reg, id_branch} = 6'($urandom);
            id_mem_read = ($urandom_range(2) == 0);
            exmem_reg_write = 1'($urandom); exmem_rd = 5'($urandom_range(7)); exmem_result = $urandom;
            memwb_reg_write = 1'($urandom); memwb_rd = 5'($urandom_range(7)); memwb_result = $urandom;
            tick();
        end
        idle();
        tick();
        @(negedge clk);
        #1 $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/id_ex_operand_stage.md
Name: id_ex_operand_stage

Overview:
- ID/EX pipeline register plus EX-stage operand preparation for the 5-stage MIPS pipeline.
- Latches decoded ID fields and inserts bubbles on load-use hazards.
- Applies EX/MEM and MEM/WB forwarding, sign-extends the immediate and applies the ALUSrc mux.
- Drives the ALU's A operand, B operand (register or immediate) and 4-bit ALU control directly; EX/MEM register consumes the control/write-register outputs.

Parameters:
- DATA_W, 32, datapath width.
- RADDR_W, 5, register address width.
- IMM_W, 16, raw immediate width.

Ports:
- clk  in  1  pipeline clock, rising edge.
- reset  in  1  synchronous, active-high.
- stall  in  1  external hold of the EX register (e.g. memory wait).
- flush  in  1  replace the incoming instruction with a bubble (branch taken).
- id_valid  in  1  ID holds a real instruction.
- id_rs_data, id_rt_data  in  DATA_W  register file read data.
- id_imm  in  IMM_W  raw immediate.
- id_rs_addr, id_rt_addr, id_rd_addr  in  RADDR_W  register indices.
- id_alu_ctrl  in  4  ALU op: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT.
- id_alu_src, id_reg_dst, id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg, id_branch  in  1 each  decoded control.
- exmem_reg_write  in  1; exmem_rd  in  RADDR_W; exmem_result  in  DATA_W  EX/MEM forward source.
- memwb_reg_write  in  1; memwb_rd  in  RADDR_W; memwb_result  in  DATA_W  MEM/WB forward source.
- ex_a  out  DATA_W  ALU operand A.
- ex_b  out  DATA_W  ALU operand B (forwarded rt or extended immediate).
- ex_alu_ctrl  out  4  ALU control.
- ex_store_data  out  DATA_W  forwarded rt for stores.
- ex_write_reg  out  RADDR_W  destination register (rd if reg_dst else rt).
- ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_branch  out  1 each.
- load_use_stall  out  1  tells PC/IF-ID to hold.

Behaviour:
- Registered state updates on rising clk. Priority: reset > flush > load_use_stall > stall > load.
- Reset: all registered fields 0 → ex_valid=0, all control outs=0, ex_alu_ctrl=0000, ex_write_reg=0, ex_a=ex_b=ex_store_data=0 (no forward matches for r0).
- Load: one-cycle latency; ID fields appear at EX outputs the cycle after capture.
- Bubble (flush or load_use_stall): ex_valid and all control bits cleared, alu_ctrl 0000, addresses 0; data fields don't-care but driven 0.
- stall (with no flush or hazard): all registered fields hold, including a held bubble.
- load_use_stall is combinational from registered state and ID inputs: ex_valid & ex_mem_read & (ex_rt_reg ≠ 0) & id_valid & (ex_rt_reg == id_rs_addr | (ex_rt_reg == id_rt_addr & ~id_alu_src)). It asserts for exactly one cycle per hazard, because the following cycle EX holds a bubble.
- Forwarding is combinational on registered rs/rt, per operand:
  - EX/MEM wins if exmem_reg_write & exmem_rd ≠ 0 & exmem_rd == reg.
  - Otherwise MEM/WB if memwb_reg_write & memwb_rd ≠ 0 & memwb_rd == reg.
  - Otherwise the latched register data.
  - Register 0 is never forwarded.
- ex_b = alu_src ? ext_imm : forwarded rt. ex_store_data is always forwarded rt.
- ext_imm = sign-extend id_imm to DATA_W, computed at capture.
- ex_write_reg = reg_dst ? rd : rt, computed at capture.

Optional Feature:
- Macro IDEX_ZEXT_LOGIC_EN.
- Defined: when alu_src=1 and alu_ctrl is 0000 or 0001 (andi/ori), the immediate is zero-extended.
- Undefined: the immediate is always sign-extended.

Decomposition:
- Shared package mips_pkg holds:
  - ALU op constants ALU_AND=4'b0000, ALU_OR=4'b0001, ALU_ADD=4'b0010, ALU_SUB=4'b0110, ALU_SLT=4'b0111.
  - DATA_W/RADDR_W defaults.
  - Forward-select encoding FWD_REG=2'b00, FWD_MEMWB=2'b01, FWD_EXMEM=2'b10.
- One sub-module: forward_unit, combinational. It compares rs/rt with exmem_rd/memwb_rd and returns 2-bit selects; instantiated once, covering both operands.

Test Plan:
- Reset mid-stream: instruction latched, then reset=1 for one edge → next cycle ex_valid=0, ex_reg_write=0, ex_alu_ctrl=0000, ex_write_reg=0.
- Double forward priority: EX rs=r3; exmem_rd=3 with result 0x11, memwb_rd=3 with result 0x22, both reg_write=1 → ex_a=0x11. Drop exmem_reg_write → ex_a=0x22. Set rs=r0 with rd=0 → no forward, ex_a=latched data.
- Load-use: EX lw, rt=r5, mem_read=1; ID add, rs=r5 → load_use_stall=1 for one cycle. Next cycle EX is a bubble (ex_valid=0) and load_use_stall=0. ID with alu_src=1 and rt=r5 only → no stall.
- Immediate: addi with imm 0xFFFC → ex_b=0xFFFFFFFC. ori with imm 0x8000 → ex_b=0x00008000 with IDEX_ZEXT_LOGIC_EN, 0xFFFF8000 without.
- Stall vs flush: stall=1 for 3 cycles → outputs unchanged. stall=1 and flush=1 together → bubble loaded, ex_valid=0.
- Write reg select: reg_dst=1 with rd=7, rt=9 → ex_write_reg=7. reg_dst=0 → ex_write_reg=9.
